// File: rtl/hub75_capture.sv
// HUB75 receive monitor: oversamples the panel bus, rebuilds each shifted row, decodes
// its bit-plane from the OE pulse width and replays the row as a tagged pixel stream.
module hub75_capture #(
    parameter int COLUMNS   = 64,
    parameter int CLK_RATIO = 4,
    parameter int OE_WIDTH  = 8
) (
    input  logic                         clk_in,
    input  logic                         reset,
    input  logic                         hub_clk,
    input  logic                         hub_latch,
    input  logic                         hub_oe,
    input  logic [3:0]                   hub_row,
    input  logic [2:0]                   hub_rgb_top,
    input  logic [2:0]                   hub_rgb_bot,
    output logic                         pix_valid,
    output logic [$clog2(COLUMNS)-1:0]   pix_column,
    output logic [3:0]                   pix_row,
    output logic [2:0]                   pix_plane,
    output logic [2:0]                   pix_rgb_top,
    output logic [2:0]                   pix_rgb_bot,
    output logic [OE_WIDTH-1:0]          oe_width,
    output logic                         err_length,
    output logic                         err_plane,
    output logic                         err_overrun
);

    localparam int COL_W  = $clog2(COLUMNS);
    localparam int PCNT_W = $clog2(COLUMNS + 2);
    localparam int PRE_W  = $clog2(CLK_RATIO + 1);
    localparam int SYNC_W = 13;

    typedef enum logic [1:0] {
        C_IDLE    = 2'd0,
        C_WAIT_OE = 2'd1,
        C_MEASURE = 2'd2,
        C_EMIT    = 2'd3
    } commit_state_t;

    // Maps a measured OE width to {valid, plane}; only powers of two 2..64 are legal.
    function automatic logic [3:0] decode_plane(input logic [OE_WIDTH-1:0] width);
        case (width)
            OE_WIDTH'(2):  decode_plane = {1'b1, 3'd0};
            OE_WIDTH'(4):  decode_plane = {1'b1, 3'd1};
            OE_WIDTH'(8):  decode_plane = {1'b1, 3'd2};
            OE_WIDTH'(16): decode_plane = {1'b1, 3'd3};
            OE_WIDTH'(32): decode_plane = {1'b1, 3'd4};
            OE_WIDTH'(64): decode_plane = {1'b1, 3'd5};
            default:       decode_plane = {1'b0, 3'd0};
        endcase
    endfunction

    logic [SYNC_W-1:0] sync1_r;
    logic [SYNC_W-1:0] sync2_r;
    logic [2:0]        edge_prev_r;

    logic              clk_s;
    logic              latch_s;
    logic              oe_s;
    logic [3:0]        row_s;
    logic [5:0]        rgb_s;
    logic              clk_rise_s;
    logic              latch_rise_s;
    logic              oe_rise_s;
    logic              oe_fall_s;

    logic [COL_W-1:0]  col_cnt_r;
    logic [PCNT_W-1:0] pix_cnt_r;
    logic [PCNT_W-1:0] pix_cnt_upd_s;
    logic              line_valid_s;
    logic              line_short_s;
    logic              commit_s;

    logic [5:0]        shift_mem_r [COLUMNS];
    logic [5:0]        hold_mem_r  [COLUMNS];

    commit_state_t     state_r;
    logic [3:0]        line_row_r;
    logic [OE_WIDTH-1:0] unit_r;
    logic [PRE_W-1:0]  presc_r;
    logic [3:0]        plane_dec_s;

    assign clk_s   = sync2_r[12];
    assign latch_s = sync2_r[11];
    assign oe_s    = sync2_r[10];
    assign row_s   = sync2_r[9:6];
    assign rgb_s   = sync2_r[5:0];

    assign clk_rise_s   = clk_s   & ~edge_prev_r[2];
    assign latch_rise_s = latch_s & ~edge_prev_r[1];
    assign oe_rise_s    = oe_s    & ~edge_prev_r[0];
    assign oe_fall_s    = ~oe_s   &  edge_prev_r[0];

    assign plane_dec_s = decode_plane(unit_r);

    // Two-stage synchroniser for the whole bus plus the previous-value copy for edge detection.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync1_r     <= {SYNC_W{1'b0}};
            sync2_r     <= {SYNC_W{1'b0}};
            edge_prev_r <= 3'b000;
        end else begin
            sync1_r     <= {hub_clk, hub_latch, hub_oe, hub_row, hub_rgb_top, hub_rgb_bot};
            sync2_r     <= sync1_r;
            edge_prev_r <= {clk_s, latch_s, oe_s};
        end
    end

    // A pixel arriving with the latch is counted before the latch is judged.
    always_comb begin
        pix_cnt_upd_s = pix_cnt_r;
        if (clk_rise_s && (pix_cnt_r != PCNT_W'(COLUMNS + 1))) begin
            pix_cnt_upd_s = pix_cnt_r + PCNT_W'(1);
        end else begin
            pix_cnt_upd_s = pix_cnt_r;
        end
        line_valid_s = latch_rise_s && (pix_cnt_upd_s == PCNT_W'(COLUMNS));
        line_short_s = latch_rise_s && (pix_cnt_upd_s != PCNT_W'(COLUMNS));
        commit_s     = line_valid_s && (state_r == C_IDLE);
    end

    // Shift-side counters: column pointer runs down from the last column, pixel count saturates.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            col_cnt_r <= COL_W'(COLUMNS - 1);
            pix_cnt_r <= {PCNT_W{1'b0}};
        end else if (latch_rise_s) begin
            col_cnt_r <= COL_W'(COLUMNS - 1);
            pix_cnt_r <= {PCNT_W{1'b0}};
        end else begin
            if (clk_rise_s) begin
                col_cnt_r <= col_cnt_r - COL_W'(1);
            end
            pix_cnt_r <= pix_cnt_upd_s;
        end
    end

    // Shift buffer write; contents need no reset.
    always_ff @(posedge clk_in) begin
        if (clk_rise_s) begin
            shift_mem_r[col_cnt_r] <= rgb_s;
        end
    end

    // Hold buffer snapshot on commit, merging a pixel that lands on the latch cycle.
    always_ff @(posedge clk_in) begin
        if (commit_s) begin
            for (int i = 0; i < COLUMNS; i++) begin
                if (clk_rise_s && (col_cnt_r == COL_W'(i))) begin
                    hold_mem_r[i] <= rgb_s;
                end else begin
                    hold_mem_r[i] <= shift_mem_r[i];
                end
            end
        end
    end

    // Commit FSM: wait for OE, measure its width, decode the plane and replay the held row.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_r     <= C_IDLE;
            line_row_r  <= 4'd0;
            unit_r      <= {OE_WIDTH{1'b0}};
            presc_r     <= {PRE_W{1'b0}};
            pix_valid   <= 1'b0;
            pix_column  <= {COL_W{1'b0}};
            pix_row     <= 4'd0;
            pix_plane   <= 3'd0;
            pix_rgb_top <= 3'd0;
            pix_rgb_bot <= 3'd0;
            oe_width    <= {OE_WIDTH{1'b0}};
            err_length  <= 1'b0;
            err_plane   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            pix_valid   <= 1'b0;
            pix_rgb_top <= 3'd0;
            pix_rgb_bot <= 3'd0;
            err_plane   <= 1'b0;
            err_length  <= line_short_s;
            err_overrun <= line_valid_s && (state_r != C_IDLE);
            case (state_r)
                C_IDLE: begin
                    if (line_valid_s) begin
                        line_row_r <= row_s;
                        state_r    <= C_WAIT_OE;
                    end
                end
                C_WAIT_OE: begin
                    if (oe_rise_s) begin
                        unit_r  <= {OE_WIDTH{1'b0}};
                        presc_r <= PRE_W'(CLK_RATIO / 2);
                        state_r <= C_MEASURE;
                    end
                end
                C_MEASURE: begin
                    if (oe_fall_s) begin
                        oe_width <= unit_r;
                        if (plane_dec_s[3]) begin
                            // First beat leaves with the decode so the burst starts without a gap.
                            pix_valid   <= 1'b1;
                            pix_column  <= COL_W'(COLUMNS - 1);
                            pix_row     <= line_row_r;
                            pix_plane   <= plane_dec_s[2:0];
                            pix_rgb_top <= hold_mem_r[COLUMNS - 1][5:3];
                            pix_rgb_bot <= hold_mem_r[COLUMNS - 1][2:0];
                            state_r     <= C_EMIT;
                        end else begin
                            err_plane <= 1'b1;
                            state_r   <= C_IDLE;
                        end
                    end else if (oe_s) begin
                        if (presc_r == PRE_W'(1)) begin
                            presc_r <= PRE_W'(CLK_RATIO);
                            if (unit_r != {OE_WIDTH{1'b1}}) begin
                                unit_r <= unit_r + OE_WIDTH'(1);
                            end
                        end else begin
                            presc_r <= presc_r - PRE_W'(1);
                        end
                    end
                end
                C_EMIT: begin
                    if (pix_column == {COL_W{1'b0}}) begin
                        state_r <= C_IDLE;
                    end else begin
                        pix_valid   <= 1'b1;
                        pix_column  <= pix_column - COL_W'(1);
                        pix_rgb_top <= hold_mem_r[pix_column - COL_W'(1)][5:3];
                        pix_rgb_bot <= hold_mem_r[pix_column - COL_W'(1)][2:0];
                    end
                end
                default: begin
                    state_r <= C_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_capture.sv
// Directed bench for hub75_capture: drives HUB75 lines and OE pulses, records replay
// beats and error pulses, and compares them with hand-computed expectations.
module tb_hub75_capture;

    logic       clk_in;
    logic       reset;
    logic       hub_clk;
    logic       hub_latch;
    logic       hub_oe;
    logic [3:0] hub_row;
    logic [2:0] hub_rgb_top;
    logic [2:0] hub_rgb_bot;
    logic       pix_valid;
    logic [5:0] pix_column;
    logic [3:0] pix_row;
    logic [2:0] pix_plane;
    logic [2:0] pix_rgb_top;
    logic [2:0] pix_rgb_bot;
    logic [7:0] oe_width;
    logic       err_length;
    logic       err_plane;
    logic       err_overrun;

    int errors = 0;
    int checks = 0;

    hub75_capture #(.COLUMNS(64), .CLK_RATIO(4), .OE_WIDTH(8)) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .hub_clk     (hub_clk),
        .hub_latch   (hub_latch),
        .hub_oe      (hub_oe),
        .hub_row     (hub_row),
        .hub_rgb_top (hub_rgb_top),
        .hub_rgb_bot (hub_rgb_bot),
        .pix_valid   (pix_valid),
        .pix_column  (pix_column),
        .pix_row     (pix_row),
        .pix_plane   (pix_plane),
        .pix_rgb_top (pix_rgb_top),
        .pix_rgb_bot (pix_rgb_bot),
        .oe_width    (oe_width),
        .err_length  (err_length),
        .err_plane   (err_plane),
        .err_overrun (err_overrun)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Beat and error-pulse recorder, sampled on the falling edge.
    logic [5:0] b_col [0:2047];
    logic [3:0] b_row [0:2047];
    logic [2:0] b_pln [0:2047];
    logic [2:0] b_top [0:2047];
    logic [2:0] b_bot [0:2047];
    int         b_cyc [0:2047];
    int beat_total = 0;
    int cyc        = 0;
    int n_len      = 0;
    int n_plane    = 0;
    int n_over     = 0;

    always @(negedge clk_in) begin
        cyc <= cyc + 1;
        if (pix_valid && beat_total < 2048) begin
            b_col[beat_total] <= pix_column;
            b_row[beat_total] <= pix_row;
            b_pln[beat_total] <= pix_plane;
            b_top[beat_total] <= pix_rgb_top;
            b_bot[beat_total] <= pix_rgb_bot;
            b_cyc[beat_total] <= cyc;
            beat_total        <= beat_total + 1;
        end
        if (err_length)  n_len   <= n_len + 1;
        if (err_plane)   n_plane <= n_plane + 1;
        if (err_overrun) n_over  <= n_over + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_pixel(input logic [2:0] top, input logic [2:0] bot);
        hub_rgb_top = top;
        hub_rgb_bot = bot;
        hub_clk     = 1'b0;
        repeat (2) @(negedge clk_in);
        hub_clk = 1'b1;
        repeat (2) @(negedge clk_in);
    endtask

    task automatic pulse_latch(input logic [3:0] row);
        hub_clk   = 1'b0;
        hub_row   = row;
        hub_latch = 1'b1;
        repeat (4) @(negedge clk_in);
        hub_latch = 1'b0;
        repeat (2) @(negedge clk_in);
    endtask

    // Columns 63 down to 63-npix+1; column c carries top=c[2:0]^key, bot=~c[2:0]^key.
    task automatic send_line(input logic [3:0] row, input logic [2:0] key, input int npix,
                             input bit do_latch);
        for (int i = 0; i < npix; i++) begin
            logic [5:0] c;
            c = 6'(63 - i);
            send_pixel(c[2:0] ^ key, (~c[2:0]) ^ key);
        end
        if (do_latch) pulse_latch(row);
    endtask

    // OE high for units*4 clk_in cycles; returns on the cycle OE drops at the pin.
    task automatic send_oe(input int units);
        hub_oe = 1'b1;
        repeat (units * 4) @(negedge clk_in);
        hub_oe = 1'b0;
    endtask

    task automatic check_burst(input string tag, input int start, input logic [3:0] row,
                               input logic [2:0] plane, input logic [2:0] key);
        int bad;
        bad = 0;
        check({tag, "_beats"}, beat_total - start, 64);
        if (beat_total - start >= 64) begin
            for (int i = 0; i < 64; i++) begin
                logic [5:0] c;
                c = 6'(63 - i);
                if (b_col[start+i] !== c || b_row[start+i] !== row ||
                    b_pln[start+i] !== plane || b_top[start+i] !== (c[2:0] ^ key) ||
                    b_bot[start+i] !== ((~c[2:0]) ^ key) ||
                    b_cyc[start+i] != b_cyc[start] + i) bad++;
            end
        end
        check({tag, "_bad_beats"}, bad, 0);
    endtask

    int s_beat, s_len, s_plane, s_over;

    task automatic snap();
        s_beat  = beat_total;
        s_len   = n_len;
        s_plane = n_plane;
        s_over  = n_over;
    endtask

    initial begin
        reset = 1'b1; hub_clk = 1'b0; hub_latch = 1'b0; hub_oe = 1'b0;
        hub_row = 4'd0; hub_rgb_top = 3'd0; hub_rgb_bot = 3'd0;
        repeat (4) @(negedge clk_in);
        check("rst_valid",  pix_valid, 0);
        check("rst_column", pix_column, 0);
        check("rst_row",    pix_row, 0);
        check("rst_plane",  pix_plane, 0);
        check("rst_oe",     oe_width, 0);
        check("rst_errs",   {err_length, err_plane, err_overrun}, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk_in);

        // Single line, row 5, plane 5, with the 3-cycle latency from the OE fall.
        snap();
        send_line(4'd5, 3'd0, 64, 1'b1);
        send_oe(64);
        @(negedge clk_in);
        check("lat_c1_valid", pix_valid, 0);
        @(negedge clk_in);
        check("lat_c2_valid", pix_valid, 0);
        @(negedge clk_in);
        check("lat_c3_valid", pix_valid, 1);
        check("lat_c3_col",   pix_column, 63);
        repeat (70) @(negedge clk_in);
        check_burst("line5", s_beat, 4'd5, 3'd5, 3'd0);
        check("line5_oe",      oe_width, 64);
        check("idle_rgb",      {pix_rgb_top, pix_rgb_bot}, 0);
        check("idle_col_hold", pix_column, 0);
        check("idle_row_hold", pix_row, 5);
        check("idle_pln_hold", pix_plane, 5);
        check("line5_errs",    (n_len - s_len) + (n_plane - s_plane) + (n_over - s_over), 0);

        // Full row cycle across all six planes.
        snap();
        for (int p = 0; p < 6; p++) begin
            int st;
            st = beat_total;
            send_line(4'd11, 3'(p), 64, 1'b1);
            send_oe(64 >> p);
            repeat (72) @(negedge clk_in);
            check_burst($sformatf("cycle_p%0d", 5 - p), st, 4'd11, 3'(5 - p), 3'(p));
        end
        check("cycle_errs", (n_len - s_len) + (n_plane - s_plane) + (n_over - s_over), 0);

        // Short line: dropped with err_length, then a good line decodes.
        snap();
        send_line(4'd3, 3'd4, 63, 1'b1);
        send_oe(16);
        repeat (72) @(negedge clk_in);
        check("short_len",   n_len - s_len, 1);
        check("short_beats", beat_total - s_beat, 0);
        snap();
        send_line(4'd3, 3'd2, 64, 1'b1);
        send_oe(32);
        repeat (72) @(negedge clk_in);
        check_burst("after_short", s_beat, 4'd3, 3'd4, 3'd2);
        check("after_short_len", n_len - s_len, 0);

        // Undecodable OE width of 5.
        snap();
        send_line(4'd4, 3'd0, 64, 1'b1);
        send_oe(5);
        repeat (20) @(negedge clk_in);
        check("bad_oe_width", oe_width, 5);
        check("bad_oe_err",   n_plane - s_plane, 1);
        check("bad_oe_beats", beat_total - s_beat, 0);

        // Second valid latch during the emit of the first line.
        snap();
        send_line(4'd7, 3'd3, 64, 1'b1);
        send_line(4'd12, 3'd5, 64, 1'b0);
        send_oe(64);
        repeat (13) @(negedge clk_in);
        pulse_latch(4'd12);
        repeat (70) @(negedge clk_in);
        check_burst("overrun_first", s_beat, 4'd7, 3'd5, 3'd3);
        check("overrun_err", n_over - s_over, 1);
        check("overrun_len", n_len - s_len, 0);
        send_oe(8);
        repeat (20) @(negedge clk_in);
        check("overrun_dropped", beat_total - s_beat, 64);

        // Reset at beat 20 of an emit.
        snap();
        send_line(4'd2, 3'd1, 64, 1'b1);
        send_oe(64);
        repeat (23) @(negedge clk_in);
        reset = 1'b1;
        @(negedge clk_in);
        check("mid_rst_valid", pix_valid, 0);
        check("mid_rst_outs",  {pix_column, pix_row, pix_plane, pix_rgb_top, pix_rgb_bot}, 0);
        check("mid_rst_oe",    oe_width, 0);
        check("mid_rst_beats", beat_total - s_beat, 21);
        reset = 1'b0;
        repeat (3) @(negedge clk_in);
        snap();
        send_line(4'd9, 3'd6, 64, 1'b1);
        send_oe(8);
        repeat (72) @(negedge clk_in);
        check_burst("post_rst", s_beat, 4'd9, 3'd2, 3'd6);
        check("post_rst_oe", oe_width, 8);
        check("post_rst_errs", (n_len - s_len) + (n_plane - s_plane) + (n_over - s_over), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
